// File: rtl/job_pool_if.sv
// Job pool control bus: spawn, kill, suspend/resume and await requests,
// plus the per-slot status and completion outputs of the controller.
interface job_pool_if #(
    parameter int NUM_JOBS = 8,
    parameter int CNT_W    = 8
);
    localparam int ID_W = $clog2(NUM_JOBS);

    logic                  spawn_valid;
    logic                  spawn_ready;
    logic [CNT_W-1:0]      spawn_len;
    logic                  spawn_dep_en;
    logic [ID_W-1:0]       spawn_dep_id;
    logic [ID_W-1:0]       spawn_id;
    logic                  kill_valid;
    logic [ID_W-1:0]       kill_id;
    logic                  kill_all;
    logic                  suspend_valid;
    logic [ID_W-1:0]       suspend_id;
    logic                  resume_valid;
    logic [ID_W-1:0]       resume_id;
    logic                  await_valid;
    logic [ID_W-1:0]       await_id;
    logic                  await_busy;
    logic                  await_done;
    logic                  await_killed;
    logic [NUM_JOBS-1:0]   done_pulse;
    logic [3*NUM_JOBS-1:0] status;
    logic [ID_W:0]         active_cnt;

    modport master (
        output spawn_valid, spawn_len, spawn_dep_en, spawn_dep_id,
        output kill_valid, kill_id, kill_all,
        output suspend_valid, suspend_id, resume_valid, resume_id,
        output await_valid, await_id,
        input  spawn_ready, spawn_id, await_busy, await_done, await_killed,
        input  done_pulse, status, active_cnt
    );

    modport slave (
        input  spawn_valid, spawn_len, spawn_dep_en, spawn_dep_id,
        input  kill_valid, kill_id, kill_all,
        input  suspend_valid, suspend_id, resume_valid, resume_id,
        input  await_valid, await_id,
        output spawn_ready, spawn_id, await_busy, await_done, await_killed,
        output done_pulse, status, active_cnt
    );
endinterface

// File: rtl/job_pool_ctrl.sv
// Job pool controller: NUM_JOBS slots, each a small lifecycle FSM driving a
// down-counter that stands in for job work. Handles allocation, dependencies,
// suspend/resume, kill/kill-all and a single outstanding await.
module job_pool_ctrl #(
    parameter int NUM_JOBS = 8,
    parameter int CNT_W    = 8
) (
    input  logic      clk,
    input  logic      rst,
    job_pool_if.slave bus
);
    localparam int ID_W = $clog2(NUM_JOBS);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RUNNING   = 3'd1;
    localparam logic [2:0] S_WAITING   = 3'd2;
    localparam logic [2:0] S_SUSPENDED = 3'd3;
    localparam logic [2:0] S_FINISHED  = 3'd4;
    localparam logic [2:0] S_KILLED    = 3'd5;

    logic [2:0]            st         [NUM_JOBS];
    logic [2:0]            st_nxt     [NUM_JOBS];
    logic [CNT_W-1:0]      rem        [NUM_JOBS];
    logic [CNT_W-1:0]      rem_nxt    [NUM_JOBS];
    logic                  dep_en     [NUM_JOBS];
    logic                  dep_en_nxt [NUM_JOBS];
    logic [ID_W-1:0]       dep_id     [NUM_JOBS];
    logic [ID_W-1:0]       dep_id_nxt [NUM_JOBS];
    logic [NUM_JOBS-1:0]   done_nxt;
    logic [NUM_JOBS-1:0]   done_r;
    logic [NUM_JOBS-1:0]   free;
    logic [NUM_JOBS-1:0]   kill_hit;
    logic [NUM_JOBS-1:0]   sus_hit;
    logic [NUM_JOBS-1:0]   res_hit;
    logic [ID_W-1:0]       alloc_id;
    logic [ID_W:0]         active_nxt;
    logic [ID_W:0]         active_r;
    logic [3*NUM_JOBS-1:0] status_w;
    logic                  spawn_fire;
    logic                  dep_live;
    logic                  await_busy_r;
    logic                  await_done_r;
    logic                  await_killed_r;
    logic [ID_W-1:0]       await_tgt;

    // Active states hold a slot; everything else is free/terminal.
    function automatic logic is_active(input logic [2:0] s);
        return (s == S_RUNNING) || (s == S_WAITING) || (s == S_SUSPENDED);
    endfunction

    // Free mask, lowest free slot and packed status from registered state.
    always_comb begin
        free     = '0;
        alloc_id = '0;
        status_w = '0;
        for (int i = 0; i < NUM_JOBS; i++) begin
            free[i]             = !is_active(st[i]);
            status_w[3*i +: 3]  = st[i];
        end
        for (int i = NUM_JOBS - 1; i >= 0; i--) begin
            if (free[i]) alloc_id = ID_W'(i);
        end
    end

    // Per-slot next state: spawn loads a free slot, then kill > suspend > resume > finish.
    always_comb begin
        spawn_fire = bus.spawn_valid && (|free);
        dep_live   = bus.spawn_dep_en && (bus.spawn_dep_id != alloc_id) &&
                     is_active(st[bus.spawn_dep_id]);
        active_nxt = '0;
        for (int i = 0; i < NUM_JOBS; i++) begin
            st_nxt[i]     = st[i];
            rem_nxt[i]    = rem[i];
            dep_en_nxt[i] = dep_en[i];
            dep_id_nxt[i] = dep_id[i];
            done_nxt[i]   = 1'b0;
            kill_hit[i]   = is_active(st[i]) &&
                            (bus.kill_all || (bus.kill_valid && (bus.kill_id == ID_W'(i))));
            sus_hit[i]    = bus.suspend_valid && (bus.suspend_id == ID_W'(i));
            res_hit[i]    = bus.resume_valid && (bus.resume_id == ID_W'(i));
            if (spawn_fire && (alloc_id == ID_W'(i))) begin
                st_nxt[i]     = dep_live ? S_WAITING : S_RUNNING;
                rem_nxt[i]    = bus.spawn_len;
                dep_en_nxt[i] = dep_live;
                dep_id_nxt[i] = bus.spawn_dep_id;
            end else if (kill_hit[i]) begin
                st_nxt[i] = S_KILLED;
            end else begin
                case (st[i])
                    S_RUNNING: begin
                        if (sus_hit[i]) begin
                            st_nxt[i] = S_SUSPENDED;
                        end else if (rem[i] == '0) begin
                            st_nxt[i]   = S_FINISHED;
                            done_nxt[i] = 1'b1;
                        end else begin
                            rem_nxt[i] = rem[i] - 1'b1;
                        end
                    end
                    S_WAITING: begin
                        if (sus_hit[i]) begin
                            st_nxt[i] = S_SUSPENDED;
                        end else if (!dep_en[i] || !is_active(st[dep_id[i]])) begin
                            st_nxt[i] = S_RUNNING;
                        end
                    end
                    S_SUSPENDED: begin
                        if (res_hit[i]) st_nxt[i] = S_WAITING;
                    end
                    default: ;
                endcase
            end
            if (is_active(st_nxt[i])) active_nxt = active_nxt + 1'b1;
        end
    end

    // Slot state, counters, dependencies, completion pulses and active count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_JOBS; i++) begin
                st[i]     <= S_IDLE;
                rem[i]    <= '0;
                dep_en[i] <= 1'b0;
                dep_id[i] <= '0;
            end
            done_r   <= '0;
            active_r <= '0;
        end else begin
            for (int i = 0; i < NUM_JOBS; i++) begin
                st[i]     <= st_nxt[i];
                rem[i]    <= rem_nxt[i];
                dep_en[i] <= dep_en_nxt[i];
                dep_id[i] <= dep_id_nxt[i];
            end
            done_r   <= done_nxt;
            active_r <= active_nxt;
        end
    end

    // Single outstanding await: latch target, report first terminal observation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            await_busy_r   <= 1'b0;
            await_done_r   <= 1'b0;
            await_killed_r <= 1'b0;
            await_tgt      <= '0;
        end else begin
            await_done_r   <= 1'b0;
            await_killed_r <= 1'b0;
            if (!await_busy_r) begin
                if (bus.await_valid) begin
                    await_busy_r <= 1'b1;
                    await_tgt    <= bus.await_id;
                end
            end else if (!is_active(st[await_tgt])) begin
                await_busy_r   <= 1'b0;
                await_done_r   <= 1'b1;
                await_killed_r <= (st[await_tgt] == S_KILLED);
            end
        end
    end

    assign bus.spawn_ready  = |free;
    assign bus.spawn_id     = alloc_id;
    assign bus.status       = status_w;
    assign bus.done_pulse   = done_r;
    assign bus.active_cnt   = active_r;
    assign bus.await_busy   = await_busy_r;
    assign bus.await_done   = await_done_r;
    assign bus.await_killed = await_killed_r;
endmodule

// File: tb/tb_job_pool_ctrl.sv
// Directed testbench for job_pool_ctrl with hand-computed expectations.
module tb_job_pool_ctrl;
    localparam int NUM_JOBS = 8;
    localparam int CNT_W    = 8;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RUNNING   = 3'd1;
    localparam logic [2:0] S_WAITING   = 3'd2;
    localparam logic [2:0] S_SUSPENDED = 3'd3;
    localparam logic [2:0] S_FINISHED  = 3'd4;
    localparam logic [2:0] S_KILLED    = 3'd5;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    job_pool_if #(.NUM_JOBS(NUM_JOBS), .CNT_W(CNT_W)) bus ();

    job_pool_ctrl #(.NUM_JOBS(NUM_JOBS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2:0] slot_st(input int i);
        return bus.status[3*i +: 3];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.spawn_valid   = 1'b0;
        bus.spawn_len     = '0;
        bus.spawn_dep_en  = 1'b0;
        bus.spawn_dep_id  = '0;
        bus.kill_valid    = 1'b0;
        bus.kill_id       = '0;
        bus.kill_all      = 1'b0;
        bus.suspend_valid = 1'b0;
        bus.suspend_id    = '0;
        bus.resume_valid  = 1'b0;
        bus.resume_id     = '0;
        bus.await_valid   = 1'b0;
        bus.await_id      = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        vectors++; if (bus.status !== '0) begin miscompares++; $display("FAIL reset_status: got %0h expected 0", bus.status); end
        vectors++; if (bus.spawn_ready !== 1'b1) begin miscompares++; $display("FAIL reset_spawn_ready: got %0b expected 1", bus.spawn_ready); end
        vectors++; if (bus.spawn_id !== 3'd0) begin miscompares++; $display("FAIL reset_spawn_id: got %0d expected 0", bus.spawn_id); end
        vectors++; if (bus.active_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_active_cnt: got %0d expected 0", bus.active_cnt); end
        vectors++; if ({bus.await_busy, bus.await_done, bus.await_killed} !== 3'b000) begin miscompares++; $display("FAIL reset_await: got %0b expected 000", {bus.await_busy, bus.await_done, bus.await_killed}); end
        vectors++; if (bus.done_pulse !== 8'h00) begin miscompares++; $display("FAIL reset_done_pulse: got %0h expected 0", bus.done_pulse); end
    endtask

    task automatic test_basic_run;
        do_reset();
        bus.spawn_valid = 1'b1;
        bus.spawn_len   = 8'd3;
        tick();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            vectors++; if (slot_st(0) !== S_RUNNING) begin miscompares++; $display("FAIL basic_running[%0d]: got %0d expected %0d", k, slot_st(0), S_RUNNING); end
            vectors++; if (bus.active_cnt !== 4'd1) begin miscompares++; $display("FAIL basic_active[%0d]: got %0d expected 1", k, bus.active_cnt); end
            vectors++; if (bus.done_pulse !== 8'h00) begin miscompares++; $display("FAIL basic_no_done[%0d]: got %0h expected 0", k, bus.done_pulse); end
            tick();
        end
        vectors++; if (slot_st(0) !== S_FINISHED) begin miscompares++; $display("FAIL basic_finished: got %0d expected %0d", slot_st(0), S_FINISHED); end
        vectors++; if (bus.done_pulse !== 8'h01) begin miscompares++; $display("FAIL basic_done_pulse: got %0h expected 01", bus.done_pulse); end
        vectors++; if (bus.active_cnt !== 4'd0) begin miscompares++; $display("FAIL basic_active_end: got %0d expected 0", bus.active_cnt); end
        tick();
        vectors++; if (bus.done_pulse !== 8'h00) begin miscompares++; $display("FAIL basic_done_once: got %0h expected 0", bus.done_pulse); end
        vectors++; if (bus.spawn_id !== 3'd0) begin miscompares++; $display("FAIL basic_reuse_id: got %0d expected 0", bus.spawn_id); end
    endtask

    task automatic test_fill_kill;
        do_reset();
        for (int k = 0; k < NUM_JOBS; k++) begin
            vectors++; if (bus.spawn_id !== 3'(k)) begin miscompares++; $display("FAIL fill_spawn_id[%0d]: got %0d expected %0d", k, bus.spawn_id, k); end
            vectors++; if (bus.spawn_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready[%0d]: got %0b expected 1", k, bus.spawn_ready); end
            bus.spawn_valid = 1'b1;
            bus.spawn_len   = 8'd20;
            tick();
        end
        clear_inputs();
        vectors++; if (bus.spawn_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %0b expected 0", bus.spawn_ready); end
        vectors++; if (bus.active_cnt !== 4'd8) begin miscompares++; $display("FAIL full_active: got %0d expected 8", bus.active_cnt); end
        bus.kill_valid  = 1'b1;
        bus.kill_id     = 3'd5;
        bus.spawn_valid = 1'b1;
        bus.spawn_len   = 8'd20;
        tick();
        clear_inputs();
        vectors++; if (slot_st(5) !== S_KILLED) begin miscompares++; $display("FAIL kill5_status: got %0d expected %0d", slot_st(5), S_KILLED); end
        vectors++; if (bus.done_pulse !== 8'h00) begin miscompares++; $display("FAIL kill5_no_done: got %0h expected 0", bus.done_pulse); end
        vectors++; if (bus.active_cnt !== 4'd7) begin miscompares++; $display("FAIL kill5_active: got %0d expected 7", bus.active_cnt); end
        vectors++; if ({bus.spawn_ready, bus.spawn_id} !== {1'b1, 3'd5}) begin miscompares++; $display("FAIL kill5_realloc: got ready=%0b id=%0d expected ready=1 id=5", bus.spawn_ready, bus.spawn_id); end
        bus.spawn_valid = 1'b1;
        bus.spawn_len   = 8'd20;
        tick();
        clear_inputs();
        vectors++; if (slot_st(5) !== S_RUNNING) begin miscompares++; $display("FAIL respawn5_status: got %0d expected %0d", slot_st(5), S_RUNNING); end
        vectors++; if (bus.active_cnt !== 4'd8) begin miscompares++; $display("FAIL respawn5_active: got %0d expected 8", bus.active_cnt); end
    endtask

    task automatic test_dependency;
        do_reset();
        bus.spawn_valid = 1'b1;
        bus.spawn_len   = 8'd10;
        tick();
        bus.spawn_len    = 8'd2;
        bus.spawn_dep_en = 1'b1;
        bus.spawn_dep_id = 3'd0;
        tick();
        clear_inputs();
        for (int k = 1; k <= 11; k++) begin
            vectors++; if (slot_st(1) !== S_WAITING) begin miscompares++; $display("FAIL dep_waiting[%0d]: got %0d expected %0d", k, slot_st(1), S_WAITING); end
            if (k == 11) begin
                vectors++; if (slot_st(0) !== S_FINISHED) begin miscompares++; $display("FAIL dep_job0_finished: got %0d expected %0d", slot_st(0), S_FINISHED); end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (slot_st(1) !== S_RUNNING) begin miscompares++; $display("FAIL dep_running[%0d]: got %0d expected %0d", k, slot_st(1), S_RUNNING); end
            tick();
        end
        vectors++; if (slot_st(1) !== S_FINISHED) begin miscompares++; $display("FAIL dep_job1_finished: got %0d expected %0d", slot_st(1), S_FINISHED); end
        vectors++; if (bus.done_pulse !== 8'h02) begin miscompares++; $display("FAIL dep_done_pulse: got %0h expected 02", bus.done_pulse); end
        // Self-dependency on the allocated slot behaves as no dependency.
        bus.spawn_valid  = 1'b1;
        bus.spawn_len    = 8'd4;
        bus.spawn_dep_en = 1'b1;
        bus.spawn_dep_id = 3'd0;
        tick();
        clear_inputs();
        vectors++; if (slot_st(0) !== S_RUNNING) begin miscompares++; $display("FAIL self_dep_running: got %0d expected %0d", slot_st(0), S_RUNNING); end
    endtask

    task automatic test_suspend_resume;
        do_reset();
        bus.spawn_valid = 1'b1;
        bus.spawn_len   = 8'd8;
        tick();
        clear_inputs();
        tick();
        tick();
        tick();
        bus.suspend_valid = 1'b1;
        bus.suspend_id    = 3'd0;
        bus.resume_valid  = 1'b1;
        bus.resume_id     = 3'd0;
        tick();
        clear_inputs();
        for (int k = 0; k < 7; k++) begin
            vectors++; if (slot_st(0) !== S_SUSPENDED) begin miscompares++; $display("FAIL suspended[%0d]: got %0d expected %0d", k, slot_st(0), S_SUSPENDED); end
            vectors++; if (bus.active_cnt !== 4'd1) begin miscompares++; $display("FAIL suspended_active[%0d]: got %0d expected 1", k, bus.active_cnt); end
            if (k == 6) begin
                bus.resume_valid = 1'b1;
                bus.resume_id    = 3'd0;
            end
            tick();
        end
        clear_inputs();
        vectors++; if (slot_st(0) !== S_WAITING) begin miscompares++; $display("FAIL resume_waiting: got %0d expected %0d", slot_st(0), S_WAITING); end
        tick();
        for (int k = 0; k < 6; k++) begin
            vectors++; if (slot_st(0) !== S_RUNNING) begin miscompares++; $display("FAIL resumed_running[%0d]: got %0d expected %0d", k, slot_st(0), S_RUNNING); end
            tick();
        end
        vectors++; if (slot_st(0) !== S_FINISHED) begin miscompares++; $display("FAIL resumed_finished: got %0d expected %0d", slot_st(0), S_FINISHED); end
        vectors++; if (bus.done_pulse !== 8'h01) begin miscompares++; $display("FAIL resumed_done: got %0h expected 01", bus.done_pulse); end
    endtask

    task automatic test_await_kill_all;
        do_reset();
        bus.spawn_valid = 1'b1;
        bus.spawn_len   = 8'd20;
        tick();
        bus.spawn_len = 8'd3;
        tick();
        clear_inputs();
        bus.await_valid = 1'b1;
        bus.await_id    = 3'd1;
        tick();
        clear_inputs();
        vectors++; if ({bus.await_busy, bus.await_done} !== 2'b10) begin miscompares++; $display("FAIL await_latched: got busy/done=%0b expected 10", {bus.await_busy, bus.await_done}); end
        tick();
        tick();
        vectors++; if (slot_st(1) !== S_RUNNING) begin miscompares++; $display("FAIL await_target_running: got %0d expected %0d", slot_st(1), S_RUNNING); end
        bus.kill_all = 1'b1;
        tick();
        clear_inputs();
        vectors++; if ({slot_st(1), slot_st(0)} !== {S_KILLED, S_KILLED}) begin miscompares++; $display("FAIL kill_all_status: got %0h expected %0h", {slot_st(1), slot_st(0)}, {S_KILLED, S_KILLED}); end
        vectors++; if (bus.done_pulse !== 8'h00) begin miscompares++; $display("FAIL kill_all_no_done: got %0h expected 0", bus.done_pulse); end
        vectors++; if ({bus.await_busy, bus.await_done} !== 2'b10) begin miscompares++; $display("FAIL await_still_busy: got %0b expected 10", {bus.await_busy, bus.await_done}); end
        vectors++; if (bus.active_cnt !== 4'd0) begin miscompares++; $display("FAIL kill_all_active: got %0d expected 0", bus.active_cnt); end
        tick();
        vectors++; if ({bus.await_busy, bus.await_done, bus.await_killed} !== 3'b011) begin miscompares++; $display("FAIL await_killed: got %0b expected 011", {bus.await_busy, bus.await_done, bus.await_killed}); end
        // Await on an idle slot completes after two edges, not killed.
        bus.await_valid = 1'b1;
        bus.await_id    = 3'd2;
        tick();
        clear_inputs();
        vectors++; if ({bus.await_busy, bus.await_done} !== 2'b10) begin miscompares++; $display("FAIL await_idle_busy: got %0b expected 10", {bus.await_busy, bus.await_done}); end
        tick();
        vectors++; if ({bus.await_busy, bus.await_done, bus.await_killed} !== 3'b010) begin miscompares++; $display("FAIL await_idle_done: got %0b expected 010", {bus.await_busy, bus.await_done, bus.await_killed}); end
        tick();
        vectors++; if (bus.await_done !== 1'b0) begin miscompares++; $display("FAIL await_done_once: got %0b expected 0", bus.await_done); end
    endtask

    task automatic test_reset_midrun;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.spawn_valid = 1'b1;
            bus.spawn_len   = 8'd30;
            tick();
        end
        clear_inputs();
        bus.await_valid = 1'b1;
        bus.await_id    = 3'd0;
        tick();
        clear_inputs();
        vectors++; if ({bus.await_busy, bus.active_cnt} !== {1'b1, 4'd3}) begin miscompares++; $display("FAIL midrun_pre: got busy=%0b cnt=%0d expected busy=1 cnt=3", bus.await_busy, bus.active_cnt); end
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (bus.status !== '0) begin miscompares++; $display("FAIL midrun_status: got %0h expected 0", bus.status); end
        vectors++; if (bus.await_busy !== 1'b0) begin miscompares++; $display("FAIL midrun_await_busy: got %0b expected 0", bus.await_busy); end
        vectors++; if (bus.active_cnt !== 4'd0) begin miscompares++; $display("FAIL midrun_active: got %0d expected 0", bus.active_cnt); end
        vectors++; if ({bus.spawn_ready, bus.spawn_id} !== {1'b1, 3'd0}) begin miscompares++; $display("FAIL midrun_spawn: got ready=%0b id=%0d expected ready=1 id=0", bus.spawn_ready, bus.spawn_id); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        clear_inputs();
        test_reset();
        test_basic_run();
        test_fill_kill();
        test_dependency();
        test_suspend_resume();
        test_await_kill_all();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/job_pool_ctrl.md
Name: job_pool_ctrl

Overview:
- Hardware process-pool controller: tracks NUM_JOBS job slots, each with a lifecycle state (IDLE, RUNNING, WAITING, SUSPENDED, FINISHED, KILLED).
- Supports spawn with automatic slot allocation, optional dependency on another job, suspend/resume, per-job kill, kill-all, and a single-outstanding await that reports when a target job terminates.
- Used as the synthesizable job/process scheduler model in process-control tests. Each job is a programmable down-counter standing in for job work.

Parameters:
- NUM_JOBS, 8, number of job slots (2..32).
- CNT_W, 8, width of job run-length counter.
- ID_W, $clog2(NUM_JOBS), slot index width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- spawn_valid  in  1  spawn request.
- spawn_ready  out  1  a free slot exists.
- spawn_len  in  CNT_W  run length L.
- spawn_dep_en  in  1  new job waits on spawn_dep_id.
- spawn_dep_id  in  ID_W  dependency slot.
- spawn_id  out  ID_W  slot that will be allocated (valid when spawn_ready).
- kill_valid  in  1  kill request.
- kill_id  in  ID_W  kill target.
- kill_all  in  1  kill every active job.
- suspend_valid  in  1  suspend request.
- suspend_id  in  ID_W  suspend target.
- resume_valid  in  1  resume request.
- resume_id  in  ID_W  resume target.
- await_valid  in  1  await request.
- await_id  in  ID_W  await target.
- await_busy  out  1  await pending.
- await_done  out  1  one-cycle pulse: target terminated.
- await_killed  out  1  qualifies await_done: target was KILLED.
- done_pulse  out  NUM_JOBS  per-slot one-cycle pulse on natural finish.
- status  out  3*NUM_JOBS  per-slot state; slot i at bits [3i+2:3i].
- active_cnt  out  ID_W+1  number of slots in RUNNING/WAITING/SUSPENDED.

Behaviour:
- Encoding: IDLE=0, RUNNING=1, WAITING=2, SUSPENDED=3, FINISHED=4, KILLED=5.
- "Free" = IDLE/FINISHED/KILLED. "Active" = RUNNING/WAITING/SUSPENDED. "Terminal" = FINISHED/KILLED/IDLE.
- Reset (async): all slots IDLE, counters 0, dependencies cleared. All outputs 0 except spawn_ready=1 and spawn_id=0.
- Allocation:
  - spawn_ready is high when any slot is free.
  - spawn_id is the lowest-index free slot; combinational from registered state.
  - Accept when spawn_valid & spawn_ready. The slot loads rem=L and the dependency.
  - Next state is WAITING if spawn_dep_en and the dependency slot is currently active; otherwise RUNNING.
  - spawn_dep_id equal to spawn_id is treated as no dependency.
- RUNNING, each cycle: if rem==0, go to FINISHED and assert done_pulse[i] in the cycle FINISHED first appears; otherwise rem--. L=0 gives one RUNNING cycle; in general L+1 RUNNING cycles.
- WAITING: go to RUNNING on the cycle after the dependency slot's registered status is terminal. Jobs without a dependency leave WAITING after one cycle.
- Suspend: RUNNING or WAITING goes to SUSPENDED; rem is frozen. Ignored for other states.
- Resume: SUSPENDED goes to WAITING, so the dependency is re-evaluated. Ignored for other states.
- Kill: an active slot goes to KILLED, with no done_pulse. kill_all kills every active slot. Kill of a free slot is ignored.
- Same-slot priority in one cycle: kill/kill_all > suspend > resume > natural completion.
- A slot freed by kill this cycle is not allocatable until the next cycle. Spawn never touches an active slot.
- Await:
  - When not busy, await_valid latches await_id and raises await_busy. await_valid while busy is ignored.
  - While busy, if the target's registered status is terminal, the next cycle gives await_done=1, await_killed=(status==KILLED) and clears await_busy.
  - An await on an already-terminal slot completes in 2 cycles.
  - An await is not cancelled by a respawn of the target; it completes on the first terminal observation.
- active_cnt is registered and reflects state after each edge.
- All state is updated on the clk rising edge only. Inputs are sampled at the edge.

Test Plan:
- Reset then spawn L=3 with no dep: spawn_id=0; status[0]=RUNNING for 4 cycles, then FINISHED; done_pulse[0] pulses once; active_cnt goes 1 then 0.
- Fill all 8 slots (L=20): spawn_ready=0 after the 8th. kill_id=5: slot 5 goes KILLED; the next spawn gets spawn_id=5 one cycle later.
- Spawn job0 L=10, then job1 with dep_en, dep_id=0, L=2: job1 stays WAITING until job0 is FINISHED, then RUNNING for 3 cycles, then FINISHED.
- Suspend job with rem=5 for 7 cycles, then resume: it is WAITING for 1 cycle, then finishes after exactly 6 more RUNNING cycles.
- Await job1 while it runs; kill_all the same cycle job1 would finish: job1 becomes KILLED with no done_pulse; await_done=1 and await_killed=1 one cycle later.
- Assert rst mid-run with 3 active jobs and an await pending: all status go IDLE immediately, await_busy=0, active_cnt=0, spawn_ready=1.
